// File: rtl/systolic_feeder_if.sv
// Bundle between the activation/weight buffers, the feeder and the 2x2 systolic array.
// master = upstream controller side, slave = the feeder itself.
interface systolic_feeder_if #(
  parameter int DATA_W = 16
);
  // Job control and weights
  logic              start;
  logic [2:0]        num_rows;
  logic [DATA_W-1:0] w_in1;
  logic [DATA_W-1:0] w_in2;
  logic [DATA_W-1:0] w_in3;
  logic [DATA_W-1:0] w_in4;

  // Activation row stream
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data0;
  logic [DATA_W-1:0] s_data1;

  // Array-side protocol
  logic              load_weight;
  logic [DATA_W-1:0] weight1;
  logic [DATA_W-1:0] weight2;
  logic [DATA_W-1:0] weight3;
  logic [DATA_W-1:0] weight4;
  logic              valid;
  logic [DATA_W-1:0] a_in1;
  logic [DATA_W-1:0] a_in2;

  // Status
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, num_rows, w_in1, w_in2, w_in3, w_in4,
    output s_valid, s_data0, s_data1,
    input  s_ready,
    input  load_weight, weight1, weight2, weight3, weight4,
    input  valid, a_in1, a_in2,
    input  busy, done, err
  );

  modport slave (
    input  start, num_rows, w_in1, w_in2, w_in3, w_in4,
    input  s_valid, s_data0, s_data1,
    output s_ready,
    output load_weight, weight1, weight2, weight3, weight4,
    output valid, a_in1, a_in2,
    output busy, done, err
  );
endinterface

// File: rtl/systolic_feeder.sv
// Input sequencer for the 2x2 systolic array: captures weights, then turns accepted
// activation rows into a one-cycle weight load followed by column-skewed valid beats.
module systolic_feeder #(
  parameter int DATA_W       = 16,
  parameter int MAX_ROWS     = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  systolic_feeder_if.slave  bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam int               DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [2:0]       MAX_ROWS_L = 3'(MAX_ROWS);

  typedef logic [DATA_W-1:0] data_t;

  logic [2:0]         state_q, state_d;
  logic [2:0]         rows_q, rows_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  data_t              skew_q, skew_d;
  data_t              w1_q, w1_d;
  data_t              w2_q, w2_d;
  data_t              w3_q, w3_d;
  data_t              w4_q, w4_d;
  logic               load_q, load_d;
  logic               valid_q, valid_d;
  data_t              a1_q, a1_d;
  data_t              a2_q, a2_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               start_legal;
  logic               s_ready;
  logic               accept;
  logic [2:0]         cnt_inc;

  assign start_legal = (bus.num_rows != 3'd0) && (bus.num_rows <= MAX_ROWS_L);
  // Ready depends only on state and the row count, never on s_valid, so no comb loop upstream.
  assign s_ready     = (state_q == ST_FEED) && (cnt_q < rows_q);
  assign accept      = s_ready && bus.s_valid;
  assign cnt_inc     = cnt_q + 3'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state_q;
    rows_d  = rows_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    skew_d  = skew_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;
    w4_d    = w4_q;
    load_d  = 1'b0;
    valid_d = 1'b0;
    a1_d    = '0;
    a2_d    = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (start_legal) begin
            rows_d  = bus.num_rows;
            w1_d    = bus.w_in1;
            w2_d    = bus.w_in2;
            w3_d    = bus.w_in3;
            w4_d    = bus.w_in4;
            load_d  = 1'b1;
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        skew_d  = '0;
        cnt_d   = '0;
        state_d = ST_FEED;
      end

      ST_FEED: begin
        if (accept) begin
          a1_d    = bus.s_data0;
          a2_d    = skew_q;
          skew_d  = bus.s_data1;
          valid_d = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_inc == rows_q) begin
            state_d = ST_FLUSH;
          end
        end
      end

      // Emits the last row's column-1 element that is still sitting in the skew register.
      ST_FLUSH: begin
        a2_d    = skew_q;
        valid_d = 1'b1;
        drain_d = '0;
        state_d = ST_DRAIN;
      end

      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rows_q  <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      skew_q  <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      w4_q    <= '0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      skew_q  <= skew_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
      w4_q    <= w4_d;
      load_q  <= load_d;
      valid_q <= valid_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.s_ready     = s_ready;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.load_weight = load_q;
  assign bus.weight1     = w1_q;
  assign bus.weight2     = w2_q;
  assign bus.weight3     = w3_q;
  assign bus.weight4     = w4_q;
  assign bus.valid       = valid_q;
  assign bus.a_in1       = a1_q;
  assign bus.a_in2       = a2_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: expected beats are queued as rows are accepted and
// popped by a negedge monitor; job latencies and control pulses are checked inline.
module tb_systolic_feeder;
  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] data_t;
  typedef struct packed {
    data_t a1;
    data_t a2;
  } beat_t;

  logic  clk   = 1'b0;
  logic  reset = 1'b1;

  int    checks          = 0;
  int    errors          = 0;
  int    cyc             = 0;
  int    start_cyc       = 0;
  int    first_valid_cyc = 0;
  int    last_valid_cyc  = 0;
  int    done_count      = 0;
  int    done_before     = 0;
  bit    arm_first       = 1'b0;
  data_t prev_d1         = '0;
  beat_t exp_q[$];

  systolic_feeder_if #(.DATA_W(DATA_W)) bus_if ();

  systolic_feeder #(
    .DATA_W      (DATA_W),
    .MAX_ROWS    (4),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Beat monitor: every valid beat must match the head of the scoreboard; idle beats carry zeros.
  initial forever begin
    beat_t b;
    @(negedge clk);
    if (bus_if.valid === 1'b1) begin
      check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        check("a_in1_beat", 32'(bus_if.a_in1), 32'(b.a1));
        check("a_in2_beat", 32'(bus_if.a_in2), 32'(b.a2));
      end
      if (arm_first) begin
        first_valid_cyc = cyc;
        arm_first       = 1'b0;
      end
      last_valid_cyc = cyc;
    end else begin
      check("a_in1_idle", 32'(bus_if.a_in1), 32'd0);
      check("a_in2_idle", 32'(bus_if.a_in2), 32'd0);
    end
    if (bus_if.done === 1'b1) done_count++;
  end

  task automatic check_weights(input data_t w1, input data_t w2, input data_t w3, input data_t w4);
    check("weight1", 32'(bus_if.weight1), 32'(w1));
    check("weight2", 32'(bus_if.weight2), 32'(w2));
    check("weight3", 32'(bus_if.weight3), 32'(w3));
    check("weight4", 32'(bus_if.weight4), 32'(w4));
  endtask

  // Called just after a rising edge; returns just after the edge that entered FEED.
  task automatic start_job(input logic [2:0] n, input data_t w1, input data_t w2,
                           input data_t w3, input data_t w4);
    bus_if.start    = 1'b1;
    bus_if.num_rows = n;
    bus_if.w_in1    = w1;
    bus_if.w_in2    = w2;
    bus_if.w_in3    = w3;
    bus_if.w_in4    = w4;
    start_cyc       = cyc;
    arm_first       = 1'b1;
    prev_d1         = '0;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.w_in1 = 16'hbeef;
    bus_if.w_in2 = 16'hbeef;
    bus_if.w_in3 = 16'hbeef;
    bus_if.w_in4 = 16'hbeef;
    check("load_weight_high", 32'(bus_if.load_weight), 32'd1);
    check("busy_in_load", 32'(bus_if.busy), 32'd1);
    check("s_ready_in_load", 32'(bus_if.s_ready), 32'd0);
    check_weights(w1, w2, w3, w4);
    @(posedge clk); #1;
    check("load_weight_one_cycle", 32'(bus_if.load_weight), 32'd0);
    check("s_ready_first_feed", 32'(bus_if.s_ready), 32'd1);
  endtask

  // Presents a row and waits (bounded) for the edge that accepts it; leaves s_valid high.
  task automatic send_row(input data_t d0, input data_t d1);
    bit taken;
    taken          = 1'b0;
    bus_if.s_valid = 1'b1;
    bus_if.s_data0 = d0;
    bus_if.s_data1 = d1;
    for (int i = 0; i < 20 && !taken; i++) begin
      taken = bus_if.s_ready;
      @(posedge clk); #1;
    end
    check("row_accepted", 32'(taken), 32'd1);
    if (taken) begin
      exp_q.push_back('{a1: d0, a2: prev_d1});
      prev_d1 = d1;
    end
  endtask

  task automatic end_rows();
    exp_q.push_back('{a1: '0, a2: prev_d1});
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus_if.done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("done_after_last_beat", 32'(cyc - last_valid_cyc), 32'd3);
    check("start_to_first_beat", 32'(first_valid_cyc - start_cyc), 32'd3);
    check("busy_clear_at_done", 32'(bus_if.busy), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus_if.done), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic illegal_start(input logic [2:0] n);
    bus_if.start    = 1'b1;
    bus_if.num_rows = n;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    check("err_pulse", 32'(bus_if.err), 32'd1);
    check("busy_after_illegal", 32'(bus_if.busy), 32'd0);
    check("no_load_on_illegal", 32'(bus_if.load_weight), 32'd0);
    @(posedge clk); #1;
    check("err_one_cycle", 32'(bus_if.err), 32'd0);
    check("still_idle", 32'(bus_if.busy), 32'd0);
  endtask

  task automatic check_all_zero();
    check("rst_valid", 32'(bus_if.valid), 32'd0);
    check("rst_load_weight", 32'(bus_if.load_weight), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_err", 32'(bus_if.err), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_s_ready", 32'(bus_if.s_ready), 32'd0);
    check("rst_a_in1", 32'(bus_if.a_in1), 32'd0);
    check("rst_a_in2", 32'(bus_if.a_in2), 32'd0);
    check_weights('0, '0, '0, '0);
  endtask

  initial begin
    bus_if.start    = 1'b0;
    bus_if.num_rows = '0;
    bus_if.w_in1    = '0;
    bus_if.w_in2    = '0;
    bus_if.w_in3    = '0;
    bus_if.w_in4    = '0;
    bus_if.s_valid  = 1'b0;
    bus_if.s_data0  = '0;
    bus_if.s_data1  = '0;

    // Reset state
    #12;
    check_all_zero();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single job, no bubbles: beats (5,0),(7,6),(0,8)
    start_job(3'd2, 16'd1, 16'd2, 16'd3, 16'd4);
    send_row(16'd5, 16'd6);
    send_row(16'd7, 16'd8);
    end_rows();
    bus_if.s_valid = 1'b0;
    wait_done();
    check_weights(16'd1, 16'd2, 16'd3, 16'd4);

    // Bubble insertion: two empty beats between (5,0) and (7,6)
    start_job(3'd2, 16'd1, 16'd2, 16'd3, 16'd4);
    send_row(16'd5, 16'd6);
    bus_if.s_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("bubble_valid_low", 32'(bus_if.valid), 32'd0);
      check("bubble_busy", 32'(bus_if.busy), 32'd1);
    end
    send_row(16'd7, 16'd8);
    end_rows();
    bus_if.s_valid = 1'b0;
    wait_done();

    // Full depth: ready must fall after the 4th row while s_valid stays high
    start_job(3'd4, 16'h11, 16'h22, 16'h33, 16'h44);
    send_row(16'd1, 16'd2);
    send_row(16'd3, 16'd4);
    send_row(16'd5, 16'd6);
    send_row(16'd7, 16'd8);
    end_rows();
    check("s_ready_low_after_last_row", 32'(bus_if.s_ready), 32'd0);
    @(posedge clk); #1;
    check("s_ready_stays_low", 32'(bus_if.s_ready), 32'd0);
    bus_if.s_valid = 1'b0;
    wait_done();

    // Illegal row counts at both ends of the legal range
    illegal_start(3'd0);
    illegal_start(3'd5);
    check_weights(16'h11, 16'h22, 16'h33, 16'h44);

    // Start while busy is ignored, including an illegal one during DRAIN
    done_before = done_count;
    start_job(3'd2, 16'd1, 16'd2, 16'd3, 16'd4);
    send_row(16'd5, 16'd6);
    bus_if.start    = 1'b1;
    bus_if.num_rows = 3'd1;
    bus_if.w_in1    = 16'd9;
    bus_if.w_in2    = 16'd9;
    bus_if.w_in3    = 16'd9;
    bus_if.w_in4    = 16'd9;
    send_row(16'd7, 16'd8);
    end_rows();
    bus_if.start   = 1'b0;
    bus_if.s_valid = 1'b0;
    check_weights(16'd1, 16'd2, 16'd3, 16'd4);
    @(posedge clk); #1;
    bus_if.start    = 1'b1;
    bus_if.num_rows = 3'd0;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    check("no_err_while_busy", 32'(bus_if.err), 32'd0);
    wait_done();
    repeat (5) @(posedge clk);
    #1;
    check("exactly_one_done", 32'(done_count - done_before), 32'd1);
    check("idle_after_busy_start", 32'(bus_if.busy), 32'd0);
    check_weights(16'd1, 16'd2, 16'd3, 16'd4);

    // Reset mid-FEED: outputs clear at once, then a fresh job behaves like the first one
    done_before = done_count;
    start_job(3'd3, 16'd1, 16'd2, 16'd3, 16'd4);
    send_row(16'd5, 16'd6);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero();
    bus_if.s_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("no_done_after_abort", 32'(done_count - done_before), 32'd0);
    start_job(3'd2, 16'd1, 16'd2, 16'd3, 16'd4);
    send_row(16'd5, 16'd6);
    send_row(16'd7, 16'd8);
    end_rows();
    bus_if.s_valid = 1'b0;
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Input sequencer that drives the 2x2 systolic-array top level. It captures a 2x2 weight set and accepts activation rows over a ready/valid stream. It then emits the array's input protocol: a one-cycle `load_weight`, followed by skewed `a_in1`/`a_in2` beats qualified by `valid`. It sits between the activation/weight buffers and the array top, and produces exactly the beat pattern that the downstream accumulators index on.

## Interface
- `DATA_W`, 16, width of activations and weights
- `MAX_ROWS`, 4, maximum activation rows per job (matches accumulator depth)
- `DRAIN_CYCLES`, 3, idle cycles after the last beat before `done`
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  job request, sampled in IDLE only
- `num_rows`  in  3  rows in this job; legal range 1..MAX_ROWS
- `w_in1`..`w_in4`  in  DATA_W each  weights, captured when `start` is accepted
- `s_valid`  in  1  activation row available
- `s_ready`  out  1  feeder accepts a row this cycle
- `s_data0`, `s_data1`  in  DATA_W each  row elements (column 0, column 1)
- `load_weight`  out  1  weight-load strobe to the array
- `weight1`..`weight4`  out  DATA_W each  registered weights to the array
- `valid`  out  1  beat qualifier to the array and accumulators
- `a_in1`, `a_in2`  out  DATA_W each  skewed activations
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle job-complete pulse
- `err`  out  1  one-cycle pulse on an illegal `start`

## Operation
- States: IDLE, LOAD, FEED, FLUSH, DRAIN.
- IDLE:
  - If `start` and 1 <= `num_rows` <= MAX_ROWS: capture `num_rows`, capture `w_in1..4`, go to LOAD.
  - If `start` with an illegal `num_rows` (0 or > MAX_ROWS): pulse `err`, stay in IDLE.
- LOAD: lasts exactly one cycle. Clear the skew register and the row counter, then go to FEED.
- FEED: `s_ready` = 1 while accepted rows < `num_rows`. `s_ready` is a combinational function of state and counter only; it never depends on `s_valid`.
  - Accept edge (`s_valid && s_ready`):
    - `a_in1 <= s_data0`, `a_in2 <= skew`, `skew <= s_data1`, `valid <= 1`.
    - Row counter increments.
    - Go to FLUSH once the counter reaches `num_rows`.
  - Non-accept edge (bubble): `valid <= 0`, `a_in1 <= 0`, `a_in2 <= 0`. The skew register holds.
- FLUSH: lasts one cycle. `a_in1 <= 0`, `a_in2 <= skew`, `valid <= 1`. Then go to DRAIN.
- DRAIN: `valid` = 0 and `a_in*` = 0 for DRAIN_CYCLES cycles. On the final cycle, pulse `done` and go to IDLE.
- The beat sequence for rows r0..r(N-1) is (r0.d0, 0), (r1.d0, r0.d1), …, (r(N-1).d0, r(N-2).d1), (0, r(N-1).d1). That is N+1 valid beats.
- `weight1..4` hold their captured values from LOAD until the next accepted `start`. Mid-job changes on `w_in*` are ignored.
- `start` while busy is ignored; no `err` is raised.

## Timing
- All outputs except `s_ready` and `busy` are registered.
- Reset values:
  - State: IDLE.
  - Zero: all data outputs, `valid`, `load_weight`, `done`, `err`, the skew register and the counters.
- `start` sampled at edge t:
  - `load_weight` = 1 during cycle t+1 only.
  - `weight*` are valid from t+1.
  - `s_ready` can first be high in cycle t+2.
- A row accepted at edge e appears on `a_in1` in cycle e+1. Its `d1` element appears on `a_in2` one beat later.
- With no bubbles, a job has this latency:
  - `start` to first `valid`: 3 cycles.
  - `valid` high for N+1 consecutive cycles.
  - `done` occurs DRAIN_CYCLES cycles after the last valid beat.
- Bubbles stretch FEED without reordering beats. `valid` never rises during LOAD or DRAIN.
- Reset asserted mid-job:
  - The job is abandoned immediately and asynchronously: all outputs go to their reset values.
  - No `done` is issued.
  - Partially accepted rows are lost.

## Test plan
- Single job, no bubbles:
  - Stimulus: `num_rows`=2, weights 1,2,3,4, rows (5,6),(7,8).
  - Required: `load_weight` for one cycle; then `valid`=1 for 3 cycles with beats (5,0),(7,6),(0,8); `done` 3 cycles after the last beat.
- Bubble insertion: same job, but `s_valid` is low for 2 cycles between the two rows.
  - Required: two `valid`=0 beats with zero data between (5,0) and (7,6); the beat sequence is otherwise identical.
- Full depth: `num_rows`=4, rows (1,2),(3,4),(5,6),(7,8).
  - Required: 5 valid beats (1,0),(3,2),(5,4),(7,6),(0,8).
  - Required: `s_ready` drops after the 4th row even though `s_valid` stays high.
- Illegal start:
  - `num_rows`=0 → `err` pulse, `busy` stays 0, no `load_weight`.
  - `num_rows`=5 → same response.
- Start while busy:
  - Stimulus: a second `start` in FEED, with new `w_in`=9.
  - Required: ignored; `weight*` keep 1..4; exactly one `done`.
- Reset mid-FEED: assert `reset` after one row is accepted.
  - Required: all outputs go to 0 and the state returns to IDLE.
  - Required: a following fresh job runs exactly as in the first scenario.
